w_mem_hash_addr_gen: RTL and testbench
======================================

// Module: w_mem_hash_addr_gen
// PURPOSE
//  Next-generation weight-SRAM address generator for one PE. Computes the hashed weight address
//  from (layer, input idx, output idx, PE idx) using a per-layer base/size table. Adds a weight-load
//  write mode with an auto-incrementing counter and a stall input. Pipelines act value/address to
//  the memory stage, aligned with SRAM read data. Sits between PE index decode and the weight SRAM/MAC.
// PARAMETERS
//  NUM_LAYER    4       layers in the base/size table
//  LAYER_W      2       layer index width (clog2 NUM_LAYER)
//  IDX_W        16      in/out activation index width
//  ACT_NO_W     6       output activation address width
//  DATA_W       16      activation / weight data width
//  WADDR_W      10      weight SRAM address width
//  HASH_K1      16'h9E37 multiplier for in_act_idx
//  HASH_K2      16'h7F4B multiplier for out_act_idx
//  HASH_K3      16'h0101 multiplier for pe_idx
// PORTS
//  clk              in   1        system clock
//  rst              in   1        synchronous active-high reset
//  pe_idx           in   6        static PE index
//  cfg_we           in   1        write layer table entry
//  cfg_layer        in   LAYER_W  table entry to write
//  cfg_base         in   WADDR_W  layer base address
//  cfg_log2         in   4        log2 of layer weight-table size, 0..WADDR_W
//  stall            in   1        downstream stall; freezes pipeline
//  comp_en          in   1        compute (read) request this cycle
//  layer_idx        in   LAYER_W  layer of request / load
//  in_act_idx       in   IDX_W    input activation index
//  out_act_idx      in   IDX_W    output activation index
//  out_act_addr     in   ACT_NO_W output activation address (passed through)
//  in_act_value     in   DATA_W   input activation value (passed through)
//  load_valid       in   1        weight-load write request
//  load_data        in   DATA_W   weight to write
//  load_ready       out  1        load accepted this cycle = load_valid & ~comp_en & ~stall
//  load_done        out  1        1-cycle pulse when load counter wraps
//  comp_en_mem      out  1        memory-stage compute enable
//  in_act_value_mem out  DATA_W   memory-stage activation value
//  out_act_addr_mem out  ACT_NO_W memory-stage output address
//  w_mem_cen        out  1        SRAM chip enable, active low
//  w_mem_wen        out  1        SRAM write enable, active low
//  w_mem_addr       out  WADDR_W  SRAM address
//  w_mem_wdata      out  DATA_W   SRAM write data
// BEHAVIOUR
//  Reset: all outputs 0 except w_mem_cen=1, w_mem_wen=1. Table: base=0, log2=WADDR_W. Load counter=0.
//  Hash (comb): h = (in_act_idx*K1 + out_act_idx*K2 + pe_idx*K3) mod 2^WADDR_W.
//  Read addr = (base[layer_idx] + (h & ((1<<log2[layer_idx])-1))) mod 2^WADDR_W.
//  Write addr = (base[layer_idx] + cnt) mod 2^WADDR_W.
//  Stage 1 (regs, t+1): w_mem_* registered.
//   - comp_en at t: cen=0, wen=1, addr=read addr.
//   - accepted load at t: cen=0, wen=0, addr=write addr, wdata=load_data.
//   - else: cen=1, wen=1; addr and wdata hold.
//  Compute has priority: load_valid with comp_en -> load_ready=0; no write; counter holds.
//  Stage 2 (t+2, aligned with SRAM rdata): comp_en_mem/in_act_value_mem/out_act_addr_mem = values at t.
//   - comp_en_mem=0 for load/idle slots.
//  Latency: comp_en -> SRAM access 1 cycle, -> comp_en_mem 2 cycles.
//   - Throughput 1/cycle when not stalled.
//  Load counter: +1 per accepted load.
//   - At cnt == (1<<log2[layer_idx])-1 it wraps to 0 and load_done pulses at t+1.
//   - log2=0 -> every load pulses load_done.
//  stall=1: stage-1/2 regs and counter hold, except w_mem_cen/w_mem_wen driven 1 next cycle;
//   the held op reissues when stall drops.
//  Config: cfg_we at t updates entry at t+1; requests sampled at t use old entry.
//   cfg_log2 > WADDR_W saturates to WADDR_W.
//  rst mid-op: all stages/counter cleared next edge; table returns to reset values.
// TESTING
//  1. Reset; comp_en, all idx=0, layer 0 -> t+1 cen=0, wen=1, addr=0x000; t+2 comp_en_mem=1.
//  2. cfg layer1 base=0x100 log2=8; comp_en in_idx=1 out_idx=0 pe=0 layer1 -> addr=0x137.
//  3. log2[2]=2, base 0x3FE; 4 loads layer2 -> addrs 0x3FE, 0x3FF, 0x000, 0x001 (wen=0); load_done on 4th.
//  4. comp_en and load_valid same cycle -> load_ready=0, read issued, counter unchanged.
//  5. stall high 3 cycles mid-stream -> cen=1 during stall; comp_en_mem held; no loss/duplicate after.
//  6. rst asserted during load burst -> next cycle cen=1, counter=0, comp_en_mem=0, table reset.

Source files
------------

// File: rtl/w_mem_hash_addr_gen_if.sv
// Request/load handshake and weight-SRAM bus between the PE front end and the address generator.
// Stall, requests and loads flow into the generator; SRAM strobes and memory-stage data flow out.
interface w_mem_hash_addr_gen_if #(
  parameter int LAYER_W  = 2,
  parameter int IDX_W    = 16,
  parameter int ACT_NO_W = 6,
  parameter int DATA_W   = 16,
  parameter int WADDR_W  = 10
);
  logic                stall;
  logic                comp_en;
  logic [LAYER_W-1:0]  layer_idx;
  logic [IDX_W-1:0]    in_act_idx;
  logic [IDX_W-1:0]    out_act_idx;
  logic [ACT_NO_W-1:0] out_act_addr;
  logic [DATA_W-1:0]   in_act_value;
  logic                load_valid;
  logic [DATA_W-1:0]   load_data;
  logic                load_ready;
  logic                load_done;
  logic                comp_en_mem;
  logic [DATA_W-1:0]   in_act_value_mem;
  logic [ACT_NO_W-1:0] out_act_addr_mem;
  logic                w_mem_cen;
  logic                w_mem_wen;
  logic [WADDR_W-1:0]  w_mem_addr;
  logic [DATA_W-1:0]   w_mem_wdata;

  modport master (
    output stall, comp_en, layer_idx, in_act_idx, out_act_idx, out_act_addr, in_act_value,
           load_valid, load_data,
    input  load_ready, load_done, comp_en_mem, in_act_value_mem, out_act_addr_mem,
           w_mem_cen, w_mem_wen, w_mem_addr, w_mem_wdata
  );

  modport slave (
    input  stall, comp_en, layer_idx, in_act_idx, out_act_idx, out_act_addr, in_act_value,
           load_valid, load_data,
    output load_ready, load_done, comp_en_mem, in_act_value_mem, out_act_addr_mem,
           w_mem_cen, w_mem_wen, w_mem_addr, w_mem_wdata
  );
endinterface

// File: rtl/w_mem_hash_addr_gen.sv
// Weight-SRAM address generator for one PE: hashed read addresses from a per-layer base/size
// table, auto-incrementing weight-load writes, and a 2-stage pipeline aligned with SRAM read data.
module w_mem_hash_addr_gen #(
  parameter int              NUM_LAYER = 4,
  parameter int              LAYER_W   = 2,
  parameter int              IDX_W     = 16,
  parameter int              ACT_NO_W  = 6,
  parameter int              DATA_W    = 16,
  parameter int              WADDR_W   = 10,
  parameter logic [15:0]     HASH_K1   = 16'h9E37,
  parameter logic [15:0]     HASH_K2   = 16'h7F4B,
  parameter logic [15:0]     HASH_K3   = 16'h0101
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         pe_idx,
  input  logic               cfg_we,
  input  logic [LAYER_W-1:0] cfg_layer,
  input  logic [WADDR_W-1:0] cfg_base,
  input  logic [3:0]         cfg_log2,
  w_mem_hash_addr_gen_if.slave bus
);

  logic [WADDR_W-1:0]  base_tbl [NUM_LAYER];
  logic [3:0]          log2_tbl [NUM_LAYER];
  logic [WADDR_W-1:0]  load_cnt;

  logic                s1_comp_en;
  logic [DATA_W-1:0]   s1_act_value;
  logic [ACT_NO_W-1:0] s1_act_addr;

  logic [WADDR_W-1:0]  hash;
  logic [WADDR_W-1:0]  size_mask;
  logic [WADDR_W-1:0]  layer_base;
  logic [WADDR_W-1:0]  read_addr;
  logic [WADDR_W-1:0]  write_addr;
  logic                load_acc;
  logic                cnt_wrap;
  logic [3:0]          cfg_log2_sat;

  // Only the low WADDR_W bits of each product survive the modulo, so multiply at that width.
  always_comb begin
    hash = WADDR_W'(bus.in_act_idx) * WADDR_W'(HASH_K1)
         + WADDR_W'(bus.out_act_idx) * WADDR_W'(HASH_K2)
         + WADDR_W'(pe_idx) * WADDR_W'(HASH_K3);
  end

  // log2 == WADDR_W shifts every bit out, giving a full-range mask.
  assign size_mask    = ~({WADDR_W{1'b1}} << log2_tbl[bus.layer_idx]);
  assign layer_base   = base_tbl[bus.layer_idx];
  assign read_addr    = layer_base + (hash & size_mask);
  assign write_addr   = layer_base + load_cnt;
  assign cnt_wrap     = (load_cnt == size_mask);
  assign load_acc     = bus.load_valid & ~bus.comp_en & ~bus.stall & ~rst;
  assign bus.load_ready = load_acc;
  assign cfg_log2_sat = (cfg_log2 > 4'(WADDR_W)) ? 4'(WADDR_W) : cfg_log2;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_LAYER; i++) begin
        base_tbl[i] <= '0;
        log2_tbl[i] <= 4'(WADDR_W);
      end
    end else if (cfg_we) begin
      base_tbl[cfg_layer] <= cfg_base;
      log2_tbl[cfg_layer] <= cfg_log2_sat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      load_cnt             <= '0;
      bus.load_done        <= 1'b0;
      s1_comp_en           <= 1'b0;
      s1_act_value         <= '0;
      s1_act_addr          <= '0;
      bus.comp_en_mem      <= 1'b0;
      bus.in_act_value_mem <= '0;
      bus.out_act_addr_mem <= '0;
      bus.w_mem_cen        <= 1'b1;
      bus.w_mem_wen        <= 1'b1;
      bus.w_mem_addr       <= '0;
      bus.w_mem_wdata      <= '0;
    end else if (bus.stall) begin
      // Pipeline freezes; only the SRAM strobes are released so nothing is re-accessed.
      bus.load_done <= 1'b0;
      bus.w_mem_cen <= 1'b1;
      bus.w_mem_wen <= 1'b1;
    end else begin
      bus.load_done        <= 1'b0;
      s1_comp_en           <= bus.comp_en;
      s1_act_value         <= bus.in_act_value;
      s1_act_addr          <= bus.out_act_addr;
      bus.comp_en_mem      <= s1_comp_en;
      bus.in_act_value_mem <= s1_act_value;
      bus.out_act_addr_mem <= s1_act_addr;
      if (bus.comp_en) begin
        bus.w_mem_cen  <= 1'b0;
        bus.w_mem_wen  <= 1'b1;
        bus.w_mem_addr <= read_addr;
      end else if (load_acc) begin
        bus.w_mem_cen   <= 1'b0;
        bus.w_mem_wen   <= 1'b0;
        bus.w_mem_addr  <= write_addr;
        bus.w_mem_wdata <= bus.load_data;
        load_cnt        <= cnt_wrap ? '0 : load_cnt + 1'b1;
        bus.load_done   <= cnt_wrap;
      end else begin
        bus.w_mem_cen <= 1'b1;
        bus.w_mem_wen <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_w_mem_hash_addr_gen.sv
// Directed bench for w_mem_hash_addr_gen: reset, hashing, config timing, loads with wrap,
// compute priority, stall hold/resume and mid-burst reset, against hand-computed values.
module tb_w_mem_hash_addr_gen;
  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] pe_idx;
  logic       cfg_we;
  logic [1:0] cfg_layer;
  logic [9:0] cfg_base;
  logic [3:0] cfg_log2;
  int         passed = 0;
  int         total  = 0;

  w_mem_hash_addr_gen_if #(.LAYER_W(2), .IDX_W(16), .ACT_NO_W(6), .DATA_W(16), .WADDR_W(10)) bus ();

  w_mem_hash_addr_gen dut (
    .clk       (clk),
    .rst       (rst),
    .pe_idx    (pe_idx),
    .cfg_we    (cfg_we),
    .cfg_layer (cfg_layer),
    .cfg_base  (cfg_base),
    .cfg_log2  (cfg_log2),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic set_op(input logic [15:0] k);
    bus.in_act_idx   = k;
    bus.out_act_addr = 6'(k);
    bus.in_act_value = k;
  endtask

  initial begin
    logic [9:0] load_addr [4];
    load_addr[0] = 10'h3FE; load_addr[1] = 10'h3FF; load_addr[2] = 10'h000; load_addr[3] = 10'h001;

    rst = 1'b1; pe_idx = '0; cfg_we = 1'b0; cfg_layer = '0; cfg_base = '0; cfg_log2 = '0;
    bus.stall = 1'b0; bus.comp_en = 1'b0; bus.layer_idx = '0; bus.in_act_idx = '0;
    bus.out_act_idx = '0; bus.out_act_addr = '0; bus.in_act_value = '0;
    bus.load_valid = 1'b1; bus.load_data = 16'hBEEF;
    step(); step();
    chk("rst_cen", 32'(bus.w_mem_cen), 1);
    chk("rst_wen", 32'(bus.w_mem_wen), 1);
    chk("rst_addr", 32'(bus.w_mem_addr), 0);
    chk("rst_comp_en_mem", 32'(bus.comp_en_mem), 0);
    chk("rst_load_ready", 32'(bus.load_ready), 0);

    // 1: read at index 0
    rst = 1'b0; bus.load_valid = 1'b0; bus.comp_en = 1'b1;
    bus.in_act_value = 16'h1234; bus.out_act_addr = 6'd5;
    step();
    chk("t1_cen", 32'(bus.w_mem_cen), 0);
    chk("t1_wen", 32'(bus.w_mem_wen), 1);
    chk("t1_addr", 32'(bus.w_mem_addr), 0);
    bus.comp_en = 1'b0;
    step();
    chk("t1_comp_en_mem", 32'(bus.comp_en_mem), 1);
    chk("t1_value_mem", 32'(bus.in_act_value_mem), 32'h1234);
    chk("t1_addr_mem", 32'(bus.out_act_addr_mem), 5);
    chk("t1_idle_cen", 32'(bus.w_mem_cen), 1);

    // 2: config timing and hashing
    cfg_we = 1'b1; cfg_layer = 2'd1; cfg_base = 10'h100; cfg_log2 = 4'd8;
    bus.comp_en = 1'b1; bus.layer_idx = 2'd1; bus.in_act_idx = 16'd1; bus.out_act_idx = 16'd0;
    step();
    chk("t2_old_entry", 32'(bus.w_mem_addr), 32'h237);
    cfg_we = 1'b0;
    step();
    chk("t2_in_hash", 32'(bus.w_mem_addr), 32'h137);
    bus.in_act_idx = 16'd0; bus.out_act_idx = 16'd1;
    step();
    chk("t2_out_hash", 32'(bus.w_mem_addr), 32'h14B);
    cfg_we = 1'b1; cfg_layer = 2'd3; cfg_base = 10'h000; cfg_log2 = 4'd15; bus.comp_en = 1'b0;
    step();
    cfg_we = 1'b0; bus.comp_en = 1'b1; bus.layer_idx = 2'd3; bus.in_act_idx = 16'd1; bus.out_act_idx = 16'd0;
    step();
    chk("t2_log2_sat", 32'(bus.w_mem_addr), 32'h237);
    bus.comp_en = 1'b0;

    // 3: four loads into a 4-entry table wrapping past the top of SRAM
    cfg_we = 1'b1; cfg_layer = 2'd2; cfg_base = 10'h3FE; cfg_log2 = 4'd2;
    step();
    cfg_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.load_valid = 1'b1; bus.layer_idx = 2'd2; bus.load_data = 16'(16'hA000 + i);
      #1;
      chk($sformatf("t3_ready%0d", i), 32'(bus.load_ready), 1);
      step();
      chk($sformatf("t3_wen%0d", i), 32'(bus.w_mem_wen), 0);
      chk($sformatf("t3_cen%0d", i), 32'(bus.w_mem_cen), 0);
      chk($sformatf("t3_addr%0d", i), 32'(bus.w_mem_addr), 32'(load_addr[i]));
      chk($sformatf("t3_wdata%0d", i), 32'(bus.w_mem_wdata), 32'(16'hA000 + i));
      chk($sformatf("t3_done%0d", i), 32'(bus.load_done), (i == 3) ? 1 : 0);
    end
    bus.load_valid = 1'b0;
    step();
    chk("t3_done_pulse", 32'(bus.load_done), 0);
    chk("t3_idle_cen", 32'(bus.w_mem_cen), 1);

    // 4: compute wins over load
    bus.comp_en = 1'b1; bus.load_valid = 1'b1; bus.layer_idx = 2'd2;
    bus.in_act_idx = 16'd0; bus.out_act_idx = 16'd0;
    #1;
    chk("t4_ready", 32'(bus.load_ready), 0);
    step();
    chk("t4_wen", 32'(bus.w_mem_wen), 1);
    chk("t4_addr", 32'(bus.w_mem_addr), 32'h3FE);
    bus.comp_en = 1'b0;
    step();
    chk("t4_cnt_held_wen", 32'(bus.w_mem_wen), 0);
    chk("t4_cnt_held_addr", 32'(bus.w_mem_addr), 32'h3FE);
    bus.load_valid = 1'b0;

    // 5: stall for three cycles mid-stream
    bus.layer_idx = 2'd0; bus.out_act_idx = 16'd0; bus.comp_en = 1'b1; set_op(16'd1);
    step();
    chk("t5_op1_addr", 32'(bus.w_mem_addr), 32'h237);
    set_op(16'd2); bus.stall = 1'b1;
    step();
    chk("t5_stall_cen", 32'(bus.w_mem_cen), 1);
    chk("t5_stall_addr", 32'(bus.w_mem_addr), 32'h237);
    chk("t5_stall_mem", 32'(bus.comp_en_mem), 0);
    step(); step();
    chk("t5_stall3_cen", 32'(bus.w_mem_cen), 1);
    chk("t5_stall3_mem", 32'(bus.comp_en_mem), 0);
    bus.stall = 1'b0;
    step();
    chk("t5_op2_addr", 32'(bus.w_mem_addr), 32'h06E);
    chk("t5_op2_cen", 32'(bus.w_mem_cen), 0);
    chk("t5_op1_mem", 32'(bus.comp_en_mem), 1);
    chk("t5_op1_addr_mem", 32'(bus.out_act_addr_mem), 1);
    set_op(16'd3);
    step();
    chk("t5_op3_addr", 32'(bus.w_mem_addr), 32'h2A5);
    chk("t5_op2_addr_mem", 32'(bus.out_act_addr_mem), 2);
    chk("t5_op2_value_mem", 32'(bus.in_act_value_mem), 2);
    bus.comp_en = 1'b0;
    step();
    chk("t5_op3_addr_mem", 32'(bus.out_act_addr_mem), 3);
    chk("t5_op3_mem", 32'(bus.comp_en_mem), 1);
    step();
    chk("t5_drain_mem", 32'(bus.comp_en_mem), 0);

    // 6: reset during activity
    bus.comp_en = 1'b1; set_op(16'd1);
    step();
    rst = 1'b1; bus.comp_en = 1'b0; bus.load_valid = 1'b1; bus.layer_idx = 2'd2;
    step();
    chk("t6_cen", 32'(bus.w_mem_cen), 1);
    chk("t6_wen", 32'(bus.w_mem_wen), 1);
    chk("t6_comp_en_mem", 32'(bus.comp_en_mem), 0);
    chk("t6_addr", 32'(bus.w_mem_addr), 0);
    rst = 1'b0;
    step();
    chk("t6_table_cnt_wen", 32'(bus.w_mem_wen), 0);
    chk("t6_table_cnt_addr", 32'(bus.w_mem_addr), 0);
    bus.load_valid = 1'b0;

    // PE index contribution
    pe_idx = 6'd3; bus.comp_en = 1'b1; bus.layer_idx = 2'd0; bus.in_act_idx = 16'd0; bus.out_act_idx = 16'd0;
    step();
    chk("pe_hash", 32'(bus.w_mem_addr), 32'h303);
    bus.comp_en = 1'b0;
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
